inv_factorial: RTL and testbench
================================

Name: inv_factorial

Overview:
- Iterative inverse-factorial unit: given a W-bit value, finds the largest n with n! <= value and flags whether value == n! exactly.
- Decode-side counterpart of the team's factorial engine. It uses the same level start/done handshake, so a bench or host can chain factorial -> inv_factorial and check the round trip.
- Multi-cycle datapath, one multiply-and-compare per cycle, controlled by a 4-state FSM.

Parameters:
- W, 16, width of input value and of the compare operand.
- NW, 4, width of result n; the internal k counter saturates at 2^NW-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clock clk
- start  input  1  level request; sampled in IDLE, must stay high to hold result
- val  input  W  operand; captured only in LOAD, ignored otherwise
- busy  output  1  high in LOAD and CALC
- done  output  1  high only in DONE
- n  output  NW  result; valid while done=1, else 0
- exact  output  1  1 when val_q == n!; valid while done=1, else 0
- err  output  1  1 when val_q == 0 (no n exists); valid while done=1, else 0

Behaviour:
- Registers:
  - state (2b)
  - val_q (W)
  - prod (2W, holds k!)
  - k (NW)
  - n_q, exact_q, err_q
- Reset (async): state=IDLE, val_q=0, prod=1, k=1, n_q=0, exact_q=0, err_q=0. Consequently busy=done=n=exact=err=0.
- IDLE: if start=1 at clock edge -> LOAD; else stay.
- LOAD:
  - val_q<=val, prod<=1, k<=1.
  - If val==0: err_q<=1, n_q<=0, exact_q<=0, -> DONE.
  - Else: err_q<=0, -> CALC.
- CALC, each cycle: nxt = prod * (k+1), computed at full 2W width so it never overflows for W=16.
  - If nxt <= val_q and k != 2^NW-1: prod<=nxt, k<=k+1, stay in CALC.
  - Else: n_q<=k, exact_q<=(prod==val_q), -> DONE.
- DONE:
  - done=1; n/exact/err drive the registered results.
  - Stay while start=1; -> IDLE when start=0 (outputs return to 0 next cycle).
- Latency, counted from the edge that samples start=1 in IDLE:
  - LOAD at +1 edge.
  - n CALC cycles (n-1 accepted multiplies plus 1 rejecting compare).
  - done high after edge n+2.
  - val==0: done high after edge 2.
- Boundary cases:
  - val=1: n=1, exact=1. Smallest n>=1 is reported; 0! is never returned.
  - val=2: n=2, exact=1.
  - W=16 maximum: 8! = 40320 <= 65535 < 9!, so n<=8 and the k saturation is never reached.
  - val changing during CALC/DONE has no effect (val_q is used).
  - start dropping during LOAD/CALC does not abort; the result is computed. If start is already 0 on entering DONE, done pulses for exactly 1 cycle.
  - start held high continuously: no restart until a DONE->IDLE pass, which requires start=0 for at least 1 edge.
  - reset asserted mid-CALC or in DONE: immediate return to reset values; the next start begins a fresh computation.
- All outputs are decoded combinationally from state plus the registered results; no output depends combinationally on val or start.

Test Plan:
- Exact match: reset, val=120, start=1 held -> done rises after edge 7, n=5, exact=1, err=0. Outputs are held while start=1 and return to 0 one edge after start=0.
- Non-exact input: val=100 -> n=4, exact=0, done after edge 6. Also val=65535 -> n=8, exact=0, done after edge 10.
- Exact boundaries: val=40320 -> n=8, exact=1. val=1 -> n=1, exact=1, done after edge 3. val=2 -> n=2, exact=1.
- Zero input: val=0 -> err=1, n=0, exact=0, done after edge 2, busy high exactly 1 cycle.
- Mid-operation disturbances:
  - Change val to 7 during CALC of val=720 -> result n=6, exact=1.
  - Drop start during CALC -> done is a 1-cycle pulse, then IDLE.
- Reset mid-CALC (val=5040, reset at edge 4) -> all outputs 0 immediately. A new start with val=24 -> n=4, exact=1.

Source files
------------

// File: rtl/inv_factorial_if.sv
// Start/done handshake bundle for the inverse-factorial unit.
// The host drives start/val; the unit answers with busy/done and results.
interface inv_factorial_if #(
    parameter int W  = 16,
    parameter int NW = 4
);
    logic          start;
    logic [W-1:0]  val;
    logic          busy;
    logic          done;
    logic [NW-1:0] n;
    logic          exact;
    logic          err;

    modport master (
        output start, val,
        input  busy, done, n, exact, err
    );

    modport slave (
        input  start, val,
        output busy, done, n, exact, err
    );
endinterface

// File: rtl/inv_factorial.sv
// Iterative inverse factorial: largest n with n! <= val, plus exact flag.
// One multiply-and-compare per cycle under a 4-state FSM.
module inv_factorial #(
    parameter int W  = 16,
    parameter int NW = 4
) (
    input logic           clk,
    input logic           reset,
    inv_factorial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [NW-1:0] KMAX = '1;

    state_t          state;
    logic [W-1:0]    val_q;
    logic [2*W-1:0]  prod;
    logic [NW-1:0]   k;
    logic [NW-1:0]   n_q;
    logic            exact_q;
    logic            err_q;

    logic [2*W-1:0]  kp1;
    logic [2*W-1:0]  nxt;
    logic [2*W-1:0]  val_w;

    // Next candidate factorial (k+1)! at full width, plus widened operand.
    always_comb begin
        kp1   = {{(2*W-NW){1'b0}}, k} + {{(2*W-1){1'b0}}, 1'b1};
        nxt   = prod * kp1;
        val_w = {{W{1'b0}}, val_q};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            val_q   <= '0;
            prod    <= {{(2*W-1){1'b0}}, 1'b1};
            k       <= {{(NW-1){1'b0}}, 1'b1};
            n_q     <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) state <= LOAD;
                end
                LOAD: begin
                    val_q <= bus.val;
                    prod  <= {{(2*W-1){1'b0}}, 1'b1};
                    k     <= {{(NW-1){1'b0}}, 1'b1};
                    if (bus.val == '0) begin
                        err_q   <= 1'b1;
                        n_q     <= '0;
                        exact_q <= 1'b0;
                        state   <= DONE;
                    end else begin
                        err_q <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (nxt <= val_w && k != KMAX) begin
                        prod <= nxt;
                        k    <= k + {{(NW-1){1'b0}}, 1'b1};
                    end else begin
                        n_q     <= k;
                        exact_q <= (prod == val_w);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from state; results gated to zero outside DONE.
    always_comb begin
        bus.busy  = (state == LOAD) || (state == CALC);
        bus.done  = (state == DONE);
        bus.n     = '0;
        bus.exact = 1'b0;
        bus.err   = 1'b0;
        if (state == DONE) begin
            bus.n     = n_q;
            bus.exact = exact_q;
            bus.err   = err_q;
        end
    end

endmodule

// File: tb/tb_inv_factorial.sv
// Self-checking bench for inv_factorial: vector table plus corner sequences.
// Expected results are queued at stimulus time and popped when done rises.
module tb_inv_factorial;

    logic clk;
    logic reset;

    inv_factorial_if #(.W(16), .NW(4)) bus ();

    inv_factorial #(.W(16), .NW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        int          n;
        int          exact;
        int          err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errs    = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // hk: 0 none, 1 change val at edge he, 2 drop start at he, 3 reset at he
    task automatic apply(input exp_t e, input int hk, input int he,
                         input logic [15:0] hv);
        int   edges;
        int   bc;
        bit   got;
        exp_t r;
        @(negedge clk);
        bus.val   = e.v;
        bus.start = 1'b1;
        if (hk != 3) sb.push_back(e);
        edges = 0;
        bc    = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.busy) bc++;
            if (hk == 3 && edges == he) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_done", int'(bus.done), 0);
                chk("rst_n", int'(bus.n), 0);
                chk("rst_exact", int'(bus.exact), 0);
                chk("rst_err", int'(bus.err), 0);
                @(negedge clk);
                reset     = 1'b0;
                bus.start = 1'b0;
                return;
            end
            if (bus.done) got = 1'b1;
            else if (edges == he) begin
                if (hk == 1) bus.val = hv;
                if (hk == 2) bus.start = 1'b0;
            end
        end
        if (!got || sb.size() == 0) begin
            chk("timeout", 0, 1);
            bus.start = 1'b0;
            return;
        end
        r = sb.pop_front();
        chk("n", int'(bus.n), r.n);
        chk("exact", int'(bus.exact), r.exact);
        chk("err", int'(bus.err), r.err);
        chk("latency", edges, r.lat);
        chk("busy_cycles", bc, r.lat - 1);
        if (hk == 2) begin
            @(posedge clk);
            #1;
            chk("pulse_done", int'(bus.done), 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                #1;
                chk("hold_done", int'(bus.done), 1);
                chk("hold_n", int'(bus.n), r.n);
            end
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            chk("rel_done", int'(bus.done), 0);
            chk("rel_n", int'(bus.n), 0);
            chk("rel_exact", int'(bus.exact), 0);
            chk("rel_err", int'(bus.err), 0);
        end
    endtask

    exp_t tbl[8];
    exp_t e;

    initial begin
        tbl[0] = '{16'd120,   5, 1, 0, 7};
        tbl[1] = '{16'd100,   4, 0, 0, 6};
        tbl[2] = '{16'd65535, 8, 0, 0, 10};
        tbl[3] = '{16'd40320, 8, 1, 0, 10};
        tbl[4] = '{16'd1,     1, 1, 0, 3};
        tbl[5] = '{16'd2,     2, 1, 0, 4};
        tbl[6] = '{16'd0,     0, 0, 1, 2};
        tbl[7] = '{16'd6,     3, 1, 0, 5};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.val   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_n", int'(bus.n), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply(tbl[i], 0, 0, 16'd0);

        e = '{16'd720, 6, 1, 0, 8};
        apply(e, 1, 3, 16'd7);

        e = '{16'd120, 5, 1, 0, 7};
        apply(e, 2, 3, 16'd0);

        e = '{16'd5040, 7, 1, 0, 9};
        apply(e, 3, 4, 16'd0);

        e = '{16'd24, 4, 1, 0, 6};
        apply(e, 0, 0, 16'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
